// File: rtl/conv_result_maxpool_reader.sv
// 2x2 max-pooling reader for a conv result buffer; streams one pooled sample per window to a write port.
// Optional build macro POOL_RELU_EN fuses a ReLU after the pooled maximum.
module conv_result_maxpool_reader #(
  parameter int DATA_WIDTH         = 16,
  parameter int ADDR_WIDTH         = 12,
  parameter int CONV_RESULT_WIDTH  = 24,
  parameter int CONV_RESULT_HEIGHT = 24
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic        [ADDR_WIDTH-1:0] result_read_address,
  input  logic signed [DATA_WIDTH-1:0] result,
  output logic        [ADDR_WIDTH-1:0] pool_wr_addr,
  output logic signed [DATA_WIDTH-1:0] pool_wr_data,
  output logic                         pool_wr_en,
  output logic                         busy,
  output logic                         done
);

  localparam int PW = CONV_RESULT_WIDTH / 2;
  localparam int PH = CONV_RESULT_HEIGHT / 2;
  localparam bit DEGEN = (PW == 0) || (PH == 0);

  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] TWO      = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] BASE_M1  = ADDR_WIDTH'(CONV_RESULT_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(2 * CONV_RESULT_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(PW - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(PH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            phase_p0;
  logic [ADDR_WIDTH-1:0] col_p0;
  logic [ADDR_WIDTH-1:0] row_p0;
  logic [ADDR_WIDTH-1:0] row_base_p0;
  logic [ADDR_WIDTH-1:0] win_base_p0;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic                  vld_p1;
  logic [1:0]            phase_p1;
  logic signed [DATA_WIDTH-1:0] max_p2;

  // Signed running max; ties keep the current value.
  function automatic logic signed [DATA_WIDTH-1:0] pool_max(
    input logic signed [DATA_WIDTH-1:0] cur,
    input logic signed [DATA_WIDTH-1:0] smp
  );
    return (smp > cur) ? smp : cur;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] pool_out(
    input logic signed [DATA_WIDTH-1:0] val
  );
`ifdef POOL_RELU_EN
    return (val < 0) ? '0 : val;
`else
    return val;
`endif
  endfunction

  assign busy = (state == S_RUN) || (state == S_DRAIN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= S_IDLE;
      result_read_address <= '0;
      phase_p0            <= '0;
      col_p0              <= '0;
      row_p0              <= '0;
      row_base_p0         <= '0;
      win_base_p0         <= '0;
      wr_cnt              <= '0;
      vld_p1              <= 1'b0;
      phase_p1            <= '0;
      pool_wr_en          <= 1'b0;
      pool_wr_addr        <= '0;
      pool_wr_data        <= '0;
    end else begin
      // p0 -> p1: the sample for the address issued now arrives next cycle
      vld_p1     <= (state == S_RUN);
      phase_p1   <= phase_p0;
      pool_wr_en <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            if (DEGEN) begin
              state <= S_DONE;
            end else begin
              state               <= S_RUN;
              result_read_address <= '0;
              phase_p0            <= '0;
              col_p0              <= '0;
              row_p0              <= '0;
              row_base_p0         <= '0;
              win_base_p0         <= '0;
              wr_cnt              <= '0;
            end
          end
        end
        S_RUN: begin
          phase_p0 <= phase_p0 + 2'd1;
          case (phase_p0)
            2'd0: result_read_address <= result_read_address + ONE;
            2'd1: result_read_address <= result_read_address + BASE_M1;
            2'd2: result_read_address <= result_read_address + ONE;
            default: begin
              if (col_p0 != COL_LAST) begin
                col_p0              <= col_p0 + ONE;
                win_base_p0         <= win_base_p0 + TWO;
                result_read_address <= win_base_p0 + TWO;
              end else if (row_p0 != ROW_LAST) begin
                col_p0              <= '0;
                row_p0              <= row_p0 + ONE;
                row_base_p0         <= row_base_p0 + ROW_STEP;
                win_base_p0         <= row_base_p0 + ROW_STEP;
                result_read_address <= row_base_p0 + ROW_STEP;
              end else begin
                state <= S_DRAIN;
              end
            end
          endcase
        end
        S_DRAIN: begin
          if (pool_wr_en) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase

      // p1 -> p2: fourth sample of a window completes the max and fires the write
      if (vld_p1 && (phase_p1 == 2'd3)) begin
        pool_wr_en   <= 1'b1;
        pool_wr_addr <= wr_cnt;
        pool_wr_data <= pool_out(pool_max(max_p2, result));
        wr_cnt       <= wr_cnt + ONE;
      end
    end
  end

  // Running max is pure datapath and is always reloaded by the first sample of a window.
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      max_p2 <= (phase_p1 == 2'd0) ? result : pool_max(max_p2, result);
    end
  end

endmodule

// File: tb/tb_conv_result_maxpool_reader.sv
// Bench for conv_result_maxpool_reader: 4x4 and 5x5 instances against a window-level reference model.
module tb_conv_result_maxpool_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start4 = 1'b0, start5 = 1'b0;
  logic [11:0] a4, a5, wa4, wa5;
  logic [15:0] res4, res5, wd4, wd5;
  logic        we4, we5, busy4, busy5, done4, done5;

  logic [15:0] mem [2][25];
  int          sel = 0;
  int          compared = 0;
  int          mismatched = 0;

  logic [15:0] exp_rd [$];
  logic [15:0] exp_wd [$];
  logic [15:0] got_q  [$];
  logic [15:0] prev_q [$];

  always #5 clk = ~clk;

  conv_result_maxpool_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(12),
    .CONV_RESULT_WIDTH(4), .CONV_RESULT_HEIGHT(4)) u4 (
    .clk(clk), .reset(reset), .start(start4), .result_read_address(a4), .result(res4),
    .pool_wr_addr(wa4), .pool_wr_data(wd4), .pool_wr_en(we4), .busy(busy4), .done(done4));

  conv_result_maxpool_reader #(.DATA_WIDTH(16), .ADDR_WIDTH(12),
    .CONV_RESULT_WIDTH(5), .CONV_RESULT_HEIGHT(5)) u5 (
    .clk(clk), .reset(reset), .start(start5), .result_read_address(a5), .result(res5),
    .pool_wr_addr(wa5), .pool_wr_data(wd5), .pool_wr_en(we5), .busy(busy5), .done(done5));

  // Result buffers: one-cycle read latency.
  always @(posedge clk) begin
    res4 <= (a4 < 12'd16) ? mem[0][a4[4:0]] : 16'hDEAD;
    res5 <= (a5 < 12'd25) ? mem[1][a5[4:0]] : 16'hDEAD;
  end

  logic [11:0] o_addr, o_waddr;
  logic [15:0] o_wdata;
  logic        o_we, o_busy, o_done;
  assign o_addr  = (sel != 0) ? a5 : a4;
  assign o_waddr = (sel != 0) ? wa5 : wa4;
  assign o_wdata = (sel != 0) ? wd5 : wd4;
  assign o_we    = (sel != 0) ? we5 : we4;
  assign o_busy  = (sel != 0) ? busy5 : busy4;
  assign o_done  = (sel != 0) ? done5 : done4;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) start5 = v;
    else start4 = v;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_rd_addr"}, 32'(o_addr), 32'd0);
    check({tag, "_wr_en"},   32'(o_we),    32'd0);
    check({tag, "_wr_addr"}, 32'(o_waddr), 32'd0);
    check({tag, "_wr_data"}, 32'(o_wdata), 32'd0);
    check({tag, "_busy"},    32'(o_busy),  32'd0);
    check({tag, "_done"},    32'(o_done),  32'd0);
  endtask

  // Window-level model: list every read in visiting order and the pooled result per window.
  task automatic build_model(input int w, input int h);
    int a [4];
    int m, v;
    exp_rd.delete();
    exp_wd.delete();
    for (int r = 0; r < h / 2; r++) begin
      for (int c = 0; c < w / 2; c++) begin
        a[0] = 2 * r * w + 2 * c;
        a[1] = a[0] + 1;
        a[2] = (2 * r + 1) * w + 2 * c;
        a[3] = a[2] + 1;
        m = -100000;
        for (int j = 0; j < 4; j++) begin
          exp_rd.push_back(16'(a[j]));
          v = int'($signed(mem[sel][a[j]]));
          if (v > m) m = v;
        end
`ifdef POOL_RELU_EN
        if (m < 0) m = 0;
`endif
        exp_wd.push_back(16'(m));
      end
    end
  endtask

  // One start pulse, then cycle-by-cycle checks; k counts cycles from the first RUN cycle.
  task automatic run_map(input int w, input int h, input int repulse_at, input int reset_at);
    int  n, idx;
    logic wexp;
    build_model(w, h);
    n = exp_wd.size();
    got_q.delete();
    @(negedge clk); set_start(1'b1);
    @(negedge clk); set_start(1'b0);
    for (int k = 0; k < 4 * n + 5; k++) begin
      if (k > 0) @(negedge clk);
      if (k < 4 * n) check("rd_addr", 32'(o_addr), 32'(exp_rd[k]));
      wexp = (k >= 5) && ((k - 5) % 4 == 0) && ((k - 5) / 4 < n);
      check("wr_en", 32'(o_we), 32'(wexp));
      if (wexp) begin
        idx = (k - 5) / 4;
        check("wr_data", 32'(o_wdata), 32'(exp_wd[idx]));
        check("wr_addr", 32'(o_waddr), 32'(idx));
      end
      if (o_we) got_q.push_back(o_wdata);
      check("busy", 32'(o_busy), 32'(k < 4 * n + 2));
      check("done", 32'(o_done), 32'(k >= 4 * n + 2));
      set_start(k == repulse_at);
      if (k == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        set_start(1'b0);
        check_idle_zero("after_reset");
        reset = 1'b0;
        for (int q = 0; q < 12; q++) begin
          @(negedge clk);
          check("post_reset_wr_en", 32'(o_we), 32'd0);
          check("post_reset_busy", 32'(o_busy), 32'd0);
          check("post_reset_done", 32'(o_done), 32'd0);
        end
        return;
      end
    end
  endtask

  logic [15:0] lit [4];

  initial begin
    // Reset state on both instances
    repeat (3) @(negedge clk);
    sel = 0; check_idle_zero("reset4");
    sel = 1; check_idle_zero("reset5");
    reset = 1'b0;

    // 4x4 ramp 0..15
    sel = 0;
    for (int i = 0; i < 25; i++) mem[0][i] = 16'(i);
    run_map(4, 4, -1, -1);
    lit[0] = 16'd5; lit[1] = 16'd7; lit[2] = 16'd13; lit[3] = 16'd15;
    check("ramp_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("ramp_lit", 32'(got_q[i]), 32'(lit[i]));

    // Restart from DONE: identical reprocessing
    prev_q = got_q;
    run_map(4, 4, -1, -1);
    check("restart_count", 32'(got_q.size()), 32'(prev_q.size()));
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("restart_same", 32'(got_q[i]), 32'(prev_q[i]));

    // All-negative map -1..-16
    for (int i = 0; i < 16; i++) mem[0][i] = 16'(-(i + 1));
    run_map(4, 4, -1, -1);
`ifdef POOL_RELU_EN
    lit[0] = 16'd0; lit[1] = 16'd0; lit[2] = 16'd0; lit[3] = 16'd0;
`else
    lit[0] = 16'hFFFF; lit[1] = 16'hFFFD; lit[2] = 16'hFFF7; lit[3] = 16'hFFF5;
`endif
    for (int i = 0; i < 4 && i < got_q.size(); i++) check("neg_lit", 32'(got_q[i]), 32'(lit[i]));

    // Signed compare with ties in window 0
    for (int i = 0; i < 16; i++) mem[0][i] = 16'($urandom_range(0, 65535));
    mem[0][0] = 16'h7FFF; mem[0][1] = 16'h8000; mem[0][4] = 16'h7FFF; mem[0][5] = 16'h0000;
    run_map(4, 4, -1, -1);
    if (got_q.size() > 0) check("tie_sign", 32'(got_q[0]), 32'h7FFF);
    else check("tie_sign_count", 32'(got_q.size()), 32'd1);

    // Random 4x4 maps, one with start re-pulsed mid-run
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 16; i++) mem[0][i] = 16'($urandom_range(0, 65535));
      run_map(4, 4, (t == 1) ? 6 : -1, -1);
      check("rand4_count", 32'(got_q.size()), 32'd4);
    end

    // 5x5 ramp and random: only 4 windows, column/row 4 never read
    sel = 1;
    for (int i = 0; i < 25; i++) mem[1][i] = 16'(i);
    run_map(5, 5, -1, -1);
    check("map5_count", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 25; i++) mem[1][i] = 16'($urandom_range(0, 65535));
    run_map(5, 5, 3, -1);
    check("map5_rand_count", 32'(got_q.size()), 32'd4);

    // Reset right after the 2nd write, then a clean full map
    sel = 0;
    for (int i = 0; i < 16; i++) mem[0][i] = 16'($urandom_range(0, 65535));
    run_map(4, 4, -1, 9);
    check("reset_mid_count", 32'(got_q.size()), 32'd2);
    run_map(4, 4, -1, -1);
    check("after_reset_count", 32'(got_q.size()), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/conv_result_maxpool_reader.md
Name: conv_result_maxpool_reader

Overview:
- Downstream consumer of a convolution layer's result buffer. It is the read side of the `result_read_address` → `result` port exposed by the conv layer wrapper.
- After the conv layer signals done, it walks the CONV_RESULT_WIDTH x CONV_RESULT_HEIGHT feature map in 2x2 non-overlapping windows and computes the signed maximum of each window.
- Each pooled value is written to a downstream M10K through a simple write port, with `done` asserted once the map is finished.
- It sits between the conv wrapper and the next layer's input memory.

Parameters:
- DATA_WIDTH, 16, width of one fixed-point sample; signed two's complement.
- ADDR_WIDTH, 12, width of the read and write addresses.
- CONV_RESULT_WIDTH, 24, number of columns in the conv result map.
- CONV_RESULT_HEIGHT, 24, number of rows in the conv result map.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; normally driven by the conv layer's done.
- result_read_address  out  ADDR_WIDTH  read address into the conv result buffer.
- result  in  DATA_WIDTH  conv result buffer data; valid exactly 1 cycle after its address is presented.
- pool_wr_addr  out  ADDR_WIDTH  write address into the pooled output memory.
- pool_wr_data  out  DATA_WIDTH  pooled value to write.
- pool_wr_en  out  1  write strobe; one cycle per window.
- busy  out  1  high while the map is being processed.
- done  out  1  high once every window has been written.

Behaviour:
- Reset: all outputs go to 0 and the FSM goes to IDLE. This applies from any state, including mid-map; partial results are abandoned and no further pool_wr_en pulses occur.
- Output geometry: PW = CONV_RESULT_WIDTH/2 and PH = CONV_RESULT_HEIGHT/2, both floored. For odd dimensions the last column and/or last row is never read.
- Window addressing: window (r,c) reads these four addresses in this order, with base = CONV_RESULT_WIDTH:
  - (2r)*base + 2c
  - (2r)*base + 2c + 1
  - (2r+1)*base + 2c
  - (2r+1)*base + 2c + 1
- Address generation: addresses are formed by counters and adders only, with no multiplier; the row base advances by 2*CONV_RESULT_WIDTH per window row.
- Windows are visited in row-major order; pool_wr_addr = r*PW + c, incrementing by 1 per write starting at 0.
- FSM states:
  - IDLE → RUN on start.
  - RUN → DRAIN after the last address of the last window is issued.
  - DRAIN → DONE after the final write.
  - DONE → RUN on start (restart from window 0; done drops in the same cycle busy rises).
- start is ignored while in RUN or DRAIN.
- Pipeline timing for a window whose first address is issued in cycle t:
  - addresses are issued in cycles t..t+3;
  - samples are captured in cycles t+1..t+4;
  - the running max is loaded with the first sample and then updated with a signed compare (greater-than; ties keep the current value);
  - pool_wr_en is high for exactly cycle t+5, with pool_wr_data and pool_wr_addr valid in that cycle.
- Throughput: the next window's first address is issued in cycle t+4, giving back-to-back windows with one write every 4 cycles.
- Latency: the first write occurs 5 cycles after the first RUN cycle. Total from start to done is 4*PW*PH + 3 cycles.
- busy is high in RUN and DRAIN.
- done is high in DONE and stays high until reset or the next start.
- Degenerate map: if PW = 0 or PH = 0, start moves directly to DONE on the next cycle with no reads or writes.
- result_read_address holds its last value when idle.

Optional Feature:
- Macro: POOL_RELU_EN.
- Defined: pool_wr_data = (max < 0) ? 0 : max, i.e. ReLU fused after pooling. Timing is unchanged.
- Not defined: pool_wr_data is the raw signed max.

Test Plan:
- 4x4 map holding 0..15 in row-major order, start pulse:
  - reads 0,1,4,5 / 2,3,6,7 / 8,9,12,13 / 10,11,14,15;
  - writes {5,7,13,15} to addresses 0..3, 4 cycles apart;
  - done is asserted 19 cycles after start.
- 4x4 map of all-negative values (-1..-16):
  - with POOL_RELU_EN, all four writes are 0;
  - without it, the writes are -1,-3,-9,-11.
- Ties and sign: window {0x7FFF, 0x8000, 0x7FFF, 0} produces 0x7FFF, confirming a signed compare.
- 5x5 map: only 4 windows are written (addresses 0..3), and no address in column 4 or row 4 is ever read.
- Start re-pulsed mid-run: ignored, and the write count stays 4.
- Reset asserted after the 2nd write: all outputs are 0 the next cycle and there are no further writes. A subsequent start runs a full clean map.
- Re-start from DONE: done drops, busy rises in the same cycle, and the map is reprocessed identically.
